// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline stall/flush/forward control with multi-cycle divide hold FSM
module hazard_controller #(
  parameter int DIV_CYCLES = 33
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_is_div,
  input  logic        ex_branch_taken,
  input  logic [4:0]  ma_rd,
  input  logic [4:0]  wb_rd,
  input  logic        ma_reg_write,
  input  logic        wb_reg_write,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_write,
  output logic        id_ex_flush,
  output logic        ex_ma_bubble,
  output logic        div_start,
  output logic        div_result_sel,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [5:0] CNT_INIT = 6'(DIV_CYCLES - 1);

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic        r_div_result_sel;
  logic [31:0] r_stall_count;

  logic        w_hold;
  logic        w_issue;
  logic        w_load_use;
  logic        w_pc_write;
  logic        w_if_id_write;
  logic        w_if_id_flush;
  logic        w_id_ex_write;
  logic        w_id_ex_flush;
  logic        w_ex_ma_bubble;
  logic        w_div_start;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;

  assign w_issue = (r_state == S_IDLE) && ex_is_div;
  assign w_hold  = w_issue || (r_state == S_BUSY);

  assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Priority: reset, divide hold, taken branch, load-use, then free-running.
  always_comb begin
    w_pc_write     = 1'b1;
    w_if_id_write  = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_write  = 1'b1;
    w_id_ex_flush  = 1'b0;
    w_ex_ma_bubble = 1'b0;
    w_div_start    = 1'b0;
    if (RESET) begin
      w_pc_write = 1'b1;
    end else if (w_hold) begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_id_ex_write  = 1'b0;
      w_ex_ma_bubble = 1'b1;
      w_div_start    = w_issue;
    end else if (ex_branch_taken) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
    end
  end

  // MA holds the younger result, so it wins over WB for the same register.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (!RESET) begin
      if (ma_reg_write && (ma_rd != 5'd0) && (ma_rd == ex_rs1))
        w_fwd_a = 2'b01;
      else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs1))
        w_fwd_a = 2'b10;
      if (ma_reg_write && (ma_rd != 5'd0) && (ma_rd == ex_rs2))
        w_fwd_b = 2'b01;
      else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs2))
        w_fwd_b = 2'b10;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state          <= S_IDLE;
      r_cnt            <= 6'd0;
      r_div_result_sel <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_div_result_sel <= 1'b0;
          if (ex_is_div) begin
            r_cnt   <= CNT_INIT;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == 6'd0) begin
            r_state          <= S_DONE;
            r_div_result_sel <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        S_DONE: begin
          // EX advances on this edge, so a still-high ex_is_div is a new divide.
          r_state          <= S_IDLE;
          r_div_result_sel <= 1'b0;
        end
        default: begin
          r_state          <= S_IDLE;
          r_div_result_sel <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      r_stall_count <= 32'd0;
    else if (!w_pc_write)
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign pc_write       = w_pc_write;
  assign if_id_write    = w_if_id_write;
  assign if_id_flush    = w_if_id_flush;
  assign id_ex_write    = w_id_ex_write;
  assign id_ex_flush    = w_id_ex_flush;
  assign ex_ma_bubble   = w_ex_ma_bubble;
  assign div_start      = w_div_start;
  assign div_result_sel = r_div_result_sel;
  assign fwd_a          = w_fwd_a;
  assign fwd_b          = w_fwd_b;
  assign stall_count    = r_stall_count;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed scoreboard bench for hazard_controller
module tb_hazard_controller;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ma_rd, wb_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_is_div, ex_branch_taken;
  logic        ma_reg_write, wb_reg_write;
  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic        ex_ma_bubble, div_start, div_result_sel;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_count;

  hazard_controller #(.DIV_CYCLES(4)) dut (
    .CLK(clk), .RESET(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_is_div(ex_is_div), .ex_branch_taken(ex_branch_taken),
    .ma_rd(ma_rd), .wb_rd(wb_rd),
    .ma_reg_write(ma_reg_write), .wb_reg_write(wb_reg_write),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_ma_bubble(ex_ma_bubble),
    .div_start(div_start), .div_result_sel(div_result_sel),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_ma_bubble, div_start, div_result_sel}
  localparam logic [7:0] C_DEF   = 8'b1101_0000;
  localparam logic [7:0] C_LU    = 8'b0001_1000;
  localparam logic [7:0] C_BR    = 8'b1111_1000;
  localparam logic [7:0] C_ISSUE = 8'b0000_0110;
  localparam logic [7:0] C_HOLD  = 8'b0000_0100;
  localparam logic [7:0] C_DONE  = 8'b1101_0001;

  typedef struct {
    string       tag;
    logic [7:0]  ctl;
    logic [3:0]  fwd;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  logic [7:0] obs_ctl;
  logic [3:0] obs_fwd;
  assign obs_ctl = {pc_write, if_id_write, if_id_flush, id_ex_write,
                    id_ex_flush, ex_ma_bubble, div_start, div_result_sel};
  assign obs_fwd = {fwd_a, fwd_b};

  task automatic clr_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ma_rd = 0; wb_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_is_div = 0;
    ex_branch_taken = 0; ma_reg_write = 0; wb_reg_write = 0;
  endtask

  // Inputs are set just after a falling edge; outputs are checked 1 ns later,
  // then the bench moves on to the next falling edge (one rising edge between).
  task automatic step(input string tag, input logic [7:0] c, input logic [3:0] f, input logic [31:0] n);
    exp_t e;
    e.tag = tag; e.ctl = c; e.fwd = f; e.cnt = n;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    total++;
    assert (obs_ctl === e.ctl) else begin
      bad++; $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs_ctl, e.ctl);
    end
    total++;
    assert (obs_fwd === e.fwd) else begin
      bad++; $error("FAIL %s fwd observed=%b expected=%b", e.tag, obs_fwd, e.fwd);
    end
    total++;
    assert (stall_count === e.cnt) else begin
      bad++; $error("FAIL %s stall_count observed=%h expected=%h", e.tag, stall_count, e.cnt);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_inputs();
    rst = 1'b1;
    @(negedge clk);
    step("reset", C_DEF, 4'b0000, 32'd0);
    rst = 1'b0;
    step("idle", C_DEF, 4'b0000, 32'd0);

    // load-use through rs1, then the bubble cycle
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    step("lu_rs1", C_LU, 4'b0000, 32'd0);
    ex_mem_read = 0;
    step("lu_after", C_DEF, 4'b0000, 32'd1);
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
    step("lu_x0", C_DEF, 4'b0000, 32'd1);
    ex_rd = 9; id_rs1 = 5; id_uses_rs1 = 0; id_rs2 = 9; id_uses_rs2 = 1;
    step("lu_rs2", C_LU, 4'b0000, 32'd1);
    id_uses_rs2 = 0;
    step("lu_nouse", C_DEF, 4'b0000, 32'd2);

    // taken branch beats a matching load-use
    id_uses_rs2 = 1; ex_branch_taken = 1;
    step("br_lu", C_BR, 4'b0000, 32'd2);
    clr_inputs();
    step("br_clr", C_DEF, 4'b0000, 32'd2);

    // divide, branch in cycle 2 ignored
    ex_is_div = 1;
    step("div_c0", C_ISSUE, 4'b0000, 32'd2);
    step("div_c1", C_HOLD, 4'b0000, 32'd3);
    ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
    step("div_c2_br", C_HOLD, 4'b0000, 32'd4);
    ex_branch_taken = 0; ex_mem_read = 0;
    step("div_c3", C_HOLD, 4'b0000, 32'd5);
    step("div_c4", C_HOLD, 4'b0000, 32'd6);
    step("div_c5_done", C_DONE, 4'b0000, 32'd7);
    clr_inputs();
    step("div_after", C_DEF, 4'b0000, 32'd7);

    // forwarding priority and x0 suppression
    ex_rs1 = 7; ma_rd = 7; wb_rd = 7; ma_reg_write = 1; wb_reg_write = 1;
    step("fwd_ma", C_DEF, 4'b0100, 32'd7);
    ma_reg_write = 0;
    step("fwd_wb", C_DEF, 4'b1000, 32'd7);
    ma_rd = 0; wb_rd = 0; ex_rs1 = 0;
    step("fwd_x0", C_DEF, 4'b0000, 32'd7);
    ex_rs1 = 3; ex_rs2 = 3; ma_rd = 3; wb_rd = 3; ma_reg_write = 1;
    step("fwd_both_ma", C_DEF, 4'b0101, 32'd7);
    ex_rs1 = 4; wb_rd = 4;
    step("fwd_mix", C_DEF, 4'b1001, 32'd7);
    clr_inputs();

    // reset during BUSY, then a fresh divide with a back-to-back follower
    ex_is_div = 1;
    step("rdiv_c0", C_ISSUE, 4'b0000, 32'd7);
    step("rdiv_c1", C_HOLD, 4'b0000, 32'd8);
    rst = 1'b1;
    step("rdiv_reset", C_DEF, 4'b0000, 32'd0);
    rst = 1'b0;
    step("ndiv_c0", C_ISSUE, 4'b0000, 32'd0);
    for (int i = 1; i <= 4; i++) step($sformatf("ndiv_c%0d", i), C_HOLD, 4'b0000, 32'(i));
    step("ndiv_done", C_DONE, 4'b0000, 32'd5);
    step("b2b_c0", C_ISSUE, 4'b0000, 32'd5);
    for (int i = 1; i <= 4; i++) step($sformatf("b2b_c%0d", i), C_HOLD, 4'b0000, 32'(5 + i));
    step("b2b_done", C_DONE, 4'b0000, 32'd10);
    clr_inputs();
    step("b2b_after", C_DEF, 4'b0000, 32'd10);

    // counter wrap via backdoor preset
    dut.r_stall_count = 32'hFFFF_FFFE;
    ex_mem_read = 1; ex_rd = 6; id_rs2 = 6; id_uses_rs2 = 1;
    step("wrap_lu1", C_LU, 4'b0000, 32'hFFFF_FFFE);
    ex_mem_read = 0;
    step("wrap_mid", C_DEF, 4'b0000, 32'hFFFF_FFFF);
    ex_mem_read = 1;
    step("wrap_lu2", C_LU, 4'b0000, 32'hFFFF_FFFF);
    ex_mem_read = 0;
    step("wrap_zero", C_DEF, 4'b0000, 32'h0000_0000);

    total++;
    assert (sb.size() == 0) else begin
      bad++; $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
